// File: rtl/avr_ext_int_pkg.sv
// Shared definitions for the external-interrupt sense path: ISC encodings
// and the stability-counter width helper.
package avr_ext_int_pkg;

  // ISCn1:ISCn0 sense-control encodings
  localparam logic [1:0] C_ISC_LOW  = 2'b00;
  localparam logic [1:0] C_ISC_ANY  = 2'b01;
  localparam logic [1:0] C_ISC_FALL = 2'b10;
  localparam logic [1:0] C_ISC_RISE = 2'b11;

  // Counter width clog2(len+1), never less than one bit
  function automatic int unsigned f_cnt_w(input int unsigned len);
    return (len == 0) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ext_int_flt.sv
// Glitch filter for one synchronized pin level. The output level follows din
// only after din has differed from it for P_FLT_LEN consecutive cycles; any
// sample equal to the current level restarts the count. P_FLT_LEN of 0 or 1
// collapses to a single register stage.
//   clk   in  core clock
//   nrst  in  synchronous active-high reset
//   din   in  synchronized pin level
//   dout  out filtered level (registered)
module ext_int_flt
  import avr_ext_int_pkg::*;
#(
  parameter int unsigned P_FLT_LEN = 3,
  parameter logic        P_RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout
);

  if (P_FLT_LEN < 2) begin : g_bypass
    logic lvl_q;

    always_ff @(posedge clk) begin
      if (nrst) lvl_q <= P_RST_VAL;
      else      lvl_q <= din;
    end

    assign dout = lvl_q;
  end else begin : g_filter
    localparam int unsigned      CNT_W     = f_cnt_w(P_FLT_LEN);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(P_FLT_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // Count consecutive opposite samples; commit the new level on the last one
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (din == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_MAX) begin
        lvl_d = din;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (nrst) begin
        cnt_q <= '0;
        lvl_q <= P_RST_VAL;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign dout = lvl_q;
  end

endmodule

// File: rtl/ext_int_sense.sv
// External-interrupt sense stage for one INTn pin: glitch filter, low-level /
// edge detection per ISCn1:ISCn0, INTFn flag and the request to the core.
//   clk       in  core clock
//   nrst      in  synchronous active-high reset
//   din       in  synchronized pin level
//   isc[1:0]  in  sense control: 00 low, 01 any edge, 10 falling, 11 rising
//   en        in  interrupt enable
//   flag_clr  in  strobe: software cleared INTFn
//   irq_ack   in  strobe: core took this vector
//   pin_flt   out filtered pin level (registered)
//   int_flag  out INTFn flag (registered)
//   irq       out interrupt request, combinational from registers and inputs
//                 isc/en only, never from din
module ext_int_sense
  import avr_ext_int_pkg::*;
#(
  parameter int unsigned P_FLT_LEN = 3,
  parameter logic        P_RST_VAL = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       din,
  input  logic [1:0] isc,
  input  logic       en,
  input  logic       flag_clr,
  input  logic       irq_ack,
  output logic       pin_flt,
  output logic       int_flag,
  output logic       irq
);

  logic lvl;
  logic lvl_dly_q;
  logic flag_q, flag_d;
  logic rise, fall, set_ev;

  ext_int_flt #(
    .P_FLT_LEN(P_FLT_LEN),
    .P_RST_VAL(P_RST_VAL)
  ) u_flt (
    .clk (clk),
    .nrst(nrst),
    .din (din),
    .dout(lvl)
  );

  // Edges come only from the filtered level, so an isc change alone never sets the flag
  always_comb begin
    rise   = lvl & ~lvl_dly_q;
    fall   = ~lvl & lvl_dly_q;
    set_ev = 1'b0;
    case (isc)
      C_ISC_ANY:  set_ev = rise | fall;
      C_ISC_FALL: set_ev = fall;
      C_ISC_RISE: set_ev = rise;
      default:    set_ev = 1'b0;
    endcase
  end

  // Set beats clear; low-level mode holds the flag at zero; en does not gate latching
  always_comb begin
    flag_d = flag_q;
    if (isc == C_ISC_LOW)         flag_d = 1'b0;
    else if (set_ev)              flag_d = 1'b1;
    else if (flag_clr || irq_ack) flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      lvl_dly_q <= P_RST_VAL;
      flag_q    <= 1'b0;
    end else begin
      lvl_dly_q <= lvl;
      flag_q    <= flag_d;
    end
  end

  assign pin_flt  = lvl;
  assign int_flag = flag_q;
  assign irq      = en & ((isc == C_ISC_LOW) ? ~lvl : flag_q);

endmodule

// File: tb/tb_ext_int_sense.sv
// Bench for ext_int_sense (P_FLT_LEN=3, P_RST_VAL=1). A cycle model pushes the
// expected {pin_flt,int_flag,irq} after every clock; each scenario pops and
// compares it, and also checks hand-derived values at the points of interest.
module tb_ext_int_sense;

  localparam int unsigned LEN = 3;
  localparam logic        RST = 1'b1;

  logic       clk = 1'b0;
  logic       nrst, din, en, flag_clr, irq_ack;
  logic [1:0] isc;
  logic       pin_flt, int_flag, irq;

  always #5 clk = ~clk;

  ext_int_sense #(.P_FLT_LEN(LEN), .P_RST_VAL(RST)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .din     (din),
    .isc     (isc),
    .en      (en),
    .flag_clr(flag_clr),
    .irq_ack (irq_ack),
    .pin_flt (pin_flt),
    .int_flag(int_flag),
    .irq     (irq)
  );

  typedef logic [2:0] exp_t;  // {pin_flt, int_flag, irq}

  typedef struct packed {
    logic       rst;
    logic       d;
    logic [1:0] isc;
    logic       en;
    logic       clr;
    logic       ack;
    logic       chk;
    logic [2:0] exp;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic m_lvl, m_dly, m_flag;
  int   m_cnt;

  // Advance one clock, update the reference model, push expected outputs
  task automatic tick();
    logic rise, fall, set_ev;
    @(posedge clk);
    if (nrst) begin
      m_lvl = RST; m_dly = RST; m_cnt = 0; m_flag = 1'b0;
    end else begin
      rise = m_lvl & ~m_dly;
      fall = ~m_lvl & m_dly;
      case (isc)
        2'b01:   set_ev = rise | fall;
        2'b10:   set_ev = fall;
        2'b11:   set_ev = rise;
        default: set_ev = 1'b0;
      endcase
      if (isc == 2'b00)                m_flag = 1'b0;
      else if (set_ev)                 m_flag = 1'b1;
      else if (flag_clr || irq_ack)    m_flag = 1'b0;
      m_dly = m_lvl;
      if (din == m_lvl)                m_cnt = 0;
      else if (m_cnt < int'(LEN) - 1)  m_cnt++;
      else begin m_lvl = din; m_cnt = 0; end
    end
    #1;
    sb.push_back({m_lvl, m_flag, en & ((isc == 2'b00) ? ~m_lvl : m_flag)});
  endtask

  task automatic test_reset();
    vec_t tbl [2] = '{11'b1_1_10_1_0_0_1_100, 11'b1_1_10_1_0_0_1_100};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL reset_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL reset[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_fall_ack();
    vec_t tbl [7] = '{
      11'b0_0_10_1_0_0_1_100, 11'b0_0_10_1_0_0_1_100, 11'b0_0_10_1_0_0_1_000,
      11'b0_0_10_1_0_0_1_011, 11'b0_0_10_1_0_0_1_011, 11'b0_0_10_1_0_1_1_000,
      11'b0_0_10_1_0_0_1_000};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL fall_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL fall[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_glitch();
    vec_t tbl [12] = '{
      11'b0_1_01_1_0_0_0_000, 11'b0_1_01_1_0_0_0_000, 11'b0_1_01_1_0_0_1_100,
      11'b0_1_01_1_0_0_1_111, 11'b0_1_01_1_1_0_1_100, 11'b0_0_01_1_0_0_1_100,
      11'b0_0_01_1_0_0_1_100, 11'b0_1_01_1_0_0_1_100, 11'b0_0_01_1_0_0_1_100,
      11'b0_0_01_1_0_0_1_100, 11'b0_1_01_1_0_0_1_100, 11'b0_1_01_1_0_0_1_100};
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL glitch_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL glitch[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_masked_edge();
    vec_t tbl [9] = '{
      11'b0_0_11_0_0_0_0_000, 11'b0_0_11_0_0_0_0_000, 11'b0_0_11_0_0_0_1_000,
      11'b0_0_11_0_0_0_1_000, 11'b0_1_11_0_0_0_0_000, 11'b0_1_11_0_0_0_0_000,
      11'b0_1_11_0_0_0_1_100, 11'b0_1_11_0_0_0_1_110, 11'b0_1_11_0_0_0_1_110};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL masked_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL masked[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
    // Enabling with the flag pending raises irq without waiting for a clock
    en = 1'b1;
    #1;
    n_vec++;
    if ({int_flag, irq} !== 2'b11) begin
      n_err++; $display("FAIL masked_en_same_cycle: got flag/irq=%b expected 11", {int_flag, irq});
    end
  endtask

  task automatic test_set_wins();
    vec_t tbl [7] = '{
      11'b0_1_10_1_1_0_1_100, 11'b0_0_10_1_0_0_1_100, 11'b0_0_10_1_0_0_1_100,
      11'b0_0_10_1_0_0_1_000, 11'b0_0_10_1_1_0_1_011, 11'b0_0_10_1_0_0_1_011,
      11'b0_0_10_1_0_1_1_000};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL setwins_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL setwins[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_low_level();
    vec_t tbl [15] = '{
      11'b0_1_00_1_0_0_1_001, 11'b0_1_00_1_0_0_1_001, 11'b0_1_00_1_0_0_1_100,
      11'b0_1_00_1_0_0_1_100, 11'b0_0_00_1_0_0_1_100, 11'b0_0_00_1_0_0_1_100,
      11'b0_0_00_1_0_0_1_001, 11'b0_0_00_1_0_0_1_001, 11'b0_0_00_1_0_0_1_001,
      11'b0_0_10_1_0_0_1_000, 11'b0_0_10_1_0_0_1_000, 11'b0_1_10_1_0_0_0_000,
      11'b0_1_10_1_0_0_0_000, 11'b0_1_10_1_0_0_1_100, 11'b0_1_10_1_0_0_1_100};
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL low_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL low[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t tbl [15] = '{
      11'b0_0_01_1_0_0_0_000, 11'b0_0_01_1_0_0_0_000, 11'b0_0_01_1_0_0_1_000,
      11'b0_0_01_1_0_0_1_011, 11'b0_1_01_1_0_0_1_011, 11'b1_1_01_1_0_0_1_100,
      11'b0_1_01_1_0_0_1_100, 11'b0_1_01_1_0_0_1_100, 11'b0_1_01_1_0_0_1_100,
      11'b0_0_01_1_0_0_1_100, 11'b1_0_01_1_0_0_1_100, 11'b0_0_01_1_0_0_1_100,
      11'b0_0_01_1_0_0_1_100, 11'b0_0_01_1_0_0_1_000, 11'b0_0_01_1_0_0_1_011};
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      nrst = tbl[i].rst; din = tbl[i].d; isc = tbl[i].isc; en = tbl[i].en;
      flag_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL rstmid_model[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
      if (tbl[i].chk) begin
        n_vec++;
        if ({pin_flt, int_flag, irq} !== tbl[i].exp) begin
          n_err++; $display("FAIL rstmid[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, tbl[i].exp);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 600; i++) begin
      nrst     = ($urandom_range(0, 99) == 0);
      din      = ($urandom_range(0, 2) == 0) ? ~din : din;
      isc      = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(0, 3)) : isc;
      en       = ($urandom_range(0, 15) == 0) ? ~en : en;
      flag_clr = ($urandom_range(0, 15) == 0);
      irq_ack  = ($urandom_range(0, 15) == 0);
      tick();
      e = sb.pop_front(); n_vec++;
      if ({pin_flt, int_flag, irq} !== e) begin
        n_err++; $display("FAIL random[%0d]: got %b expected %b", i, {pin_flt, int_flag, irq}, e);
      end
    end
  endtask

  initial begin
    nrst = 1'b1; din = 1'b1; isc = 2'b10; en = 1'b1; flag_clr = 1'b0; irq_ack = 1'b0;
    test_reset();
    test_fall_ack();
    test_glitch();
    test_masked_edge();
    test_set_wins();
    test_low_level();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
